layered_substance_painter: RTL and testbench
============================================

# layered_substance_painter

Pipelined pixel compositor feeding the VGA colour outputs. It merges `LAYERS` sprite layers in fixed priority over a programmable background colour. It blanks outside the active area and supports frame-synchronous per-layer blinking and global dimming. It is the parametrised successor of the single-layer painter and sits between the sprite/platform renderers and the DAC pins.

## Interface
Parameters:
- `LAYERS`, 4, number of sprite layers; layer 0 has highest priority.
- `CW`, 4, bits per colour channel.
- `BLINK_FRAMES`, 16, frames per blink half-period; ≥1.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `layer_color`  in  [LAYERS][3][CW]  per-layer colour, channel order {0:red,1:green,2:blue}.
- `layer_transparency`  in  [LAYERS]  1 = layer transparent at this pixel.
- `bg_color`  in  [3][CW]  colour when no layer is opaque.
- `draw`  in  1  1 = pixel inside the active area.
- `frame_start`  in  1  one-cycle pulse at the start of each frame.
- `blink_mask`  in  [LAYERS]  1 = layer participates in blinking.
- `dim`  in  2  right-shift applied to every channel of the composed colour, 0..3.
- `red`, `green`, `blue`  out  CW each  registered pixel colour.
- `draw_out`  out  1  `draw` delayed to align with the colour outputs.

## Operation
- Stage 1 (select), registered:
  - Effective transparency: `eff_t[i] = layer_transparency[i] | (blink_mask[i] & blink_off)`.
  - Winner: the lowest index i with `eff_t[i]==0`.
  - Stage-1 colour = the winner's `layer_color`, or `bg_color` if every layer has eff_t=1.
  - `draw` is captured alongside the colour.
- Stage 2 (shade), registered:
  - Each channel = stage-1 channel >> `dim`, a logical shift with zero fill, width CW.
  - If the stage-1 draw is 0, all channels are forced to 0.
  - `draw_out` = stage-1 draw.
- `dim` is sampled in stage 2, in the same cycle the pixel is shaded.
- `blink_mask`, `layer_*` and `bg_color` are sampled in stage 1.
- Blink engine:
  - Frame counter `fcnt`, width clog2(BLINK_FRAMES), plus phase bit `blink_off`.
  - On each `frame_start`: if `fcnt==BLINK_FRAMES-1`, then `fcnt←0` and `blink_off` toggles; otherwise `fcnt` increments.
  - `frame_start` is counted regardless of `draw`.
  - The new `blink_off` value first affects pixels presented in the cycle after the pulse.
  - With BLINK_FRAMES=1, `blink_off` toggles on every `frame_start`.
- Reset values: `red`, `green`, `blue` = 0; `draw_out` = 0; all pipeline registers = 0; `fcnt` = 0; `blink_off` = 0 (layers visible).
- Reset asserted mid-frame clears the pipeline and restarts the blink period on the next clock edge. No partial pixel escapes: outputs read 0 in the cycle after reset is sampled.

## Timing
- Latency is exactly 2 clocks from inputs (`layer_*`, `bg_color`, `draw`) to `red`/`green`/`blue`/`draw_out`. Throughput is 1 pixel per clock, with no stalls and no handshake.
- `dim` latency is 1 clock.
- `frame_start` coincident with pixel data:
  - The pixel sampled in the same cycle uses the old `blink_off`.
  - The next cycle's pixel uses the updated value.
- `frame_start` held high for k cycles is counted as k frames; upstream must guarantee single-cycle pulses.
- Outputs change only on rising `clk`. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:**
  - Assert `reset` for 2 clocks with `draw=1` and all layers opaque at 0xF.
  - Required: `red/green/blue=0` and `draw_out=0` during reset and on the first edge after it.
  - The first valid pixel appears 2 clocks after deassertion.
- **Priority, LAYERS=4:**
  - Stimulus: layer0 transparent, layer1 opaque {3,5,7}, layer2 opaque {F,F,F}, `draw=1`, `dim=0`.
  - Required: {3,5,7} with `draw_out=1`, exactly 2 clocks later.
- **Background and blanking:**
  - All layers transparent, `bg_color={1,2,3}` → {1,2,3}.
  - Same pixel with `draw=0` → {0,0,0}, `draw_out=0`.
- **Dim:**
  - Layer0 opaque {F,8,1}, with `dim` set to 1, then 2, then 3 on consecutive cycles.
  - Required outputs, in order: {7,4,0}, {3,2,0}, {1,1,0}.
- **Blink, BLINK_FRAMES=2:**
  - Stimulus: `blink_mask=0001`, layer0 {F,0,0}, layer1 {0,F,0}; pulse `frame_start` 4 times.
  - Required: {F,0,0} before pulse 2 and from pulse 4 on; {0,F,0} between pulses 2 and 4.
  - Check the exact switch cycle: the pixel in the same cycle as pulse 2 is still {F,0,0}.
- **Streaming:**
  - Random per-cycle layers, transparency, `draw` and `dim` for 10k cycles.
  - Compare against a 2-cycle-delayed reference model, including a reset asserted mid-stream.

Source files
------------

// File: rtl/layered_substance_painter.sv
// Two-stage pixel compositor: priority layer select with frame-synchronous
// blinking, then dimming and blanking into the registered VGA colour outputs.
module layered_substance_painter #(
  parameter int unsigned LAYERS       = 4,
  parameter int unsigned CW           = 4,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LAYERS-1:0][2:0][CW-1:0] layer_color,
  input  logic [LAYERS-1:0]              layer_transparency,
  input  logic [2:0][CW-1:0]             bg_color,
  input  logic                           draw,
  input  logic                           frame_start,
  input  logic [LAYERS-1:0]              blink_mask,
  input  logic [1:0]                     dim,
  output logic [CW-1:0]                  red,
  output logic [CW-1:0]                  green,
  output logic [CW-1:0]                  blue,
  output logic                           draw_out
);

  // A single-frame period still needs a one-bit counter that never leaves 0.
  localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic               blink_off_q, blink_off_d;
  logic [LAYERS-1:0]  eff_t;
  logic               found;
  logic [2:0][CW-1:0] s1_color_q, s1_color_d;
  logic               s1_draw_q, s1_draw_d;
  logic [2:0][CW-1:0] out_color_q, out_color_d;
  logic               draw_out_q, draw_out_d;

  always_comb begin
    fcnt_d      = fcnt_q;
    blink_off_d = blink_off_q;
    if (frame_start) begin
      if (fcnt_q == FLAST) begin
        fcnt_d      = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    eff_t      = layer_transparency | (blink_mask & {LAYERS{blink_off_q}});
    s1_color_d = bg_color;
    found      = 1'b0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (!eff_t[i] && !found) begin
        s1_color_d = layer_color[i];
        found      = 1'b1;
      end
    end
    s1_draw_d = draw;
  end

  always_comb begin
    out_color_d = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      out_color_d[c] = s1_draw_q ? (s1_color_q[c] >> dim) : '0;
    end
    draw_out_d = s1_draw_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q      <= '0;
      blink_off_q <= 1'b0;
      s1_color_q  <= '0;
      s1_draw_q   <= 1'b0;
      out_color_q <= '0;
      draw_out_q  <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      blink_off_q <= blink_off_d;
      s1_color_q  <= s1_color_d;
      s1_draw_q   <= s1_draw_d;
      out_color_q <= out_color_d;
      draw_out_q  <= draw_out_d;
    end
  end

  assign red      = out_color_q[0];
  assign green    = out_color_q[1];
  assign blue     = out_color_q[2];
  assign draw_out = draw_out_q;

endmodule

// File: tb/tb_layered_substance_painter.sv
// Self-checking bench for layered_substance_painter: directed literal checks
// plus a randomized stream compared against a behavioural model every cycle.
module tb_layered_substance_painter;

  localparam int unsigned LAYERS = 4;
  localparam int unsigned CW     = 4;
  localparam int unsigned BF     = 2;

  typedef logic [2:0][CW-1:0] rgb_t;

  logic                           clk = 1'b0;
  logic                           reset;
  logic [LAYERS-1:0][2:0][CW-1:0] layer_color;
  logic [LAYERS-1:0]              layer_transparency;
  rgb_t                           bg_color;
  logic                           draw;
  logic                           frame_start;
  logic [LAYERS-1:0]              blink_mask;
  logic [1:0]                     dim;
  logic [CW-1:0]                  red, green, blue;
  logic                           draw_out;

  layered_substance_painter #(.LAYERS(LAYERS), .CW(CW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .layer_color(layer_color),
    .layer_transparency(layer_transparency), .bg_color(bg_color), .draw(draw),
    .frame_start(frame_start), .blink_mask(blink_mask), .dim(dim),
    .red(red), .green(green), .blue(blue), .draw_out(draw_out)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;

  // Model state: pulses seen since reset, pixel awaiting shading, visible output.
  int unsigned pulses = 0;
  rgb_t        m_pend = '0;
  logic        m_pend_draw = 1'b0;
  rgb_t        m_out = '0;
  logic        m_out_draw = 1'b0;

  function automatic rgb_t compose(logic boff);
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (!(layer_transparency[i] || (blink_mask[i] && boff))) return layer_color[i];
    end
    return bg_color;
  endfunction

  function automatic rgb_t shade(rgb_t c, logic [1:0] d);
    rgb_t r;
    for (int unsigned k = 0; k < 3; k++) r[k] = CW'(int'(c[k]) / (1 << d));
    return r;
  endfunction

  task automatic tick();
    logic [3*CW:0] got, exp;
    logic boff;
    @(posedge clk);
    #1;
    cyc++;
    boff = ((pulses / BF) % 2) == 1;
    if (reset) begin
      pulses = 0; m_pend = '0; m_pend_draw = 1'b0; m_out = '0; m_out_draw = 1'b0;
    end else begin
      m_out       = m_pend_draw ? shade(m_pend, dim) : '0;
      m_out_draw  = m_pend_draw;
      m_pend      = compose(boff);
      m_pend_draw = draw;
      if (frame_start) pulses++;
    end
    got = {draw_out, red, green, blue};
    exp = {m_out_draw, m_out[0], m_out[1], m_out[2]};
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got %h expected %h", cyc, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [3*CW:0] exp);
    logic [3*CW:0] got;
    got = {draw_out, red, green, blue};
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_all(input logic [CW-1:0] v);
    for (int unsigned i = 0; i < LAYERS; i++) layer_color[i] = {v, v, v};
  endtask

  initial begin
    reset = 1'b1; draw = 1'b1; frame_start = 1'b0; blink_mask = '0; dim = 2'd0;
    layer_transparency = '0; bg_color = '0; set_all(4'hF);

    // Reset with opaque white pixels present
    tick(); chk("reset_c1", 13'h0000);
    tick(); chk("reset_c2", 13'h0000);
    reset = 1'b0;
    tick(); chk("reset_first_edge", 13'h0000);
    tick(); chk("reset_first_pixel", {1'b1, 4'hF, 4'hF, 4'hF});

    // Priority
    layer_transparency = 4'b0001;
    layer_color[0] = {4'h1, 4'h1, 4'h1};
    layer_color[1] = {4'h7, 4'h5, 4'h3};
    layer_color[2] = {4'hF, 4'hF, 4'hF};
    tick(); tick(); chk("priority", {1'b1, 4'h3, 4'h5, 4'h7});

    // Background and blanking
    layer_transparency = '1; bg_color = {4'h3, 4'h2, 4'h1};
    tick(); tick(); chk("background", {1'b1, 4'h1, 4'h2, 4'h3});
    draw = 1'b0;
    tick(); tick(); chk("blanking", 13'h0000);
    draw = 1'b1;

    // Dim, one step per cycle on the same pixel
    layer_transparency = '0; layer_color[0] = {4'h1, 4'h8, 4'hF};
    tick();
    dim = 2'd1; tick(); chk("dim1", {1'b1, 4'h7, 4'h4, 4'h0});
    dim = 2'd2; tick(); chk("dim2", {1'b1, 4'h3, 4'h2, 4'h0});
    dim = 2'd3; tick(); chk("dim3", {1'b1, 4'h1, 4'h1, 4'h0});
    dim = 2'd0;

    // Blink with a two-frame half-period
    reset = 1'b1; tick(); reset = 1'b0;
    blink_mask = 4'b0001; layer_color[0] = {4'h0, 4'h0, 4'hF};
    layer_color[1] = {4'h0, 4'hF, 4'h0};
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); chk("blink_after_p1", {1'b1, 4'hF, 4'h0, 4'h0});
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); chk("blink_p2_same_cycle", {1'b1, 4'hF, 4'h0, 4'h0});
    tick(); chk("blink_p2_next", {1'b1, 4'h0, 4'hF, 4'h0});
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); chk("blink_p3", {1'b1, 4'h0, 4'hF, 4'h0});
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); chk("blink_p4_same_cycle", {1'b1, 4'h0, 4'hF, 4'h0});
    tick(); chk("blink_after_p4", {1'b1, 4'hF, 4'h0, 4'h0});

    // Randomized streaming against the model, with a forced mid-stream reset
    for (int unsigned n = 0; n < 10000; n++) begin
      for (int unsigned i = 0; i < LAYERS; i++) layer_color[i] = rgb_t'($urandom());
      layer_transparency = LAYERS'($urandom());
      blink_mask         = LAYERS'($urandom());
      bg_color           = rgb_t'($urandom());
      draw               = ($urandom_range(0, 7) != 0);
      dim                = 2'($urandom());
      frame_start        = ($urandom_range(0, 11) == 0);
      reset              = (n == 5000) || ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0; frame_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
